// File: rtl/sl811_pkg.sv
// Shared definitions for the SL811 access path: bus port selects, FSM state
// encodings and SL811 register indices used by the engines above the sequencer.
package sl811_pkg;

  localparam logic [2:0] ADDR_PORT_DEF = 3'd0;
  localparam logic [2:0] DATA_PORT_DEF = 3'd4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_WGET  = 3'd2;
  localparam state_t ST_WR    = 3'd3;
  localparam state_t ST_RD    = 3'd4;
  localparam state_t ST_RHOLD = 3'd5;
  localparam state_t ST_NEXT  = 3'd6;

  // SL811 register map (indices written to the address port)
  localparam logic [7:0] REG_HOST_CTRL    = 8'h00;
  localparam logic [7:0] REG_HOST_BASE    = 8'h01;
  localparam logic [7:0] REG_HOST_LEN     = 8'h02;
  localparam logic [7:0] REG_HOST_PID_EP  = 8'h03;
  localparam logic [7:0] REG_HOST_DEVADDR = 8'h04;
  localparam logic [7:0] REG_CTRL1        = 8'h05;
  localparam logic [7:0] REG_INT_ENABLE   = 8'h06;
  localparam logic [7:0] REG_INT_STATUS   = 8'h0D;
  localparam logic [7:0] REG_SOF_LOW      = 8'h0E;
  localparam logic [7:0] REG_CTRL2        = 8'h0F;
  localparam logic [7:0] REG_BUF_BASE     = 8'h10;

  function automatic logic [31:0] bus_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/sl811_bus_cycle.sv
// Holds one registered strobe/address/data set on the usb_sl811 port until the
// slave stops stalling; a new load takes priority over the completion drop.
module sl811_bus_cycle
  import sl811_pkg::*;
(
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        ld_rd,
  input  logic        ld_wr,
  input  logic [2:0]  ld_port,
  input  logic [7:0]  ld_data,
  input  logic        m_stall,
  input  logic [31:0] m_data_i,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_data_o,
  output logic        cmpl,
  output logic [7:0]  rd_byte
);

  logic [7:0] data_q;
  logic [23:0] unused_hi;

  assign unused_hi = m_data_i[31:8];
  assign cmpl      = (m_read | m_write) & ~m_stall;
  assign m_data_o  = bus_word(data_q);

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      m_address <= 3'd0;
      data_q    <= 8'h00;
    end else if (ld_rd | ld_wr) begin
      m_read    <= ld_rd;
      m_write   <= ld_wr & ~ld_rd;
      m_address <= ld_port;
      data_q    <= ld_rd ? 8'h00 : ld_data;
    end else if (cmpl) begin
      m_read  <= 1'b0;
      m_write <= 1'b0;
    end
  end

  // Read byte only moves on a completing read, so it stays put while held
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      rd_byte <= 8'h00;
    end else if (m_read && !m_stall) begin
      rd_byte <= m_data_i[7:0];
    end
  end

endmodule

// File: rtl/sl811_access_seq.sv
// Turns indirect SL811 register/buffer burst requests into address-port then
// data-port cycles on the usb_sl811 slave port.
//
// state | meaning
// IDLE  | ready for a request
// ADDR  | writing register index to the address port
// WGET  | waiting for the next write byte
// WR    | writing one byte to the data port
// RD    | reading one byte from the data port
// RHOLD | presenting the read byte until the consumer takes it
// NEXT  | count down; finish or advance to the next byte
module sl811_access_seq
  import sl811_pkg::*;
#(
  parameter logic [2:0] ADDR_PORT = ADDR_PORT_DEF,
  parameter logic [2:0] DATA_PORT = DATA_PORT_DEF,
  parameter bit         AUTO_INC  = 1'b1
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [7:0]  wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [7:0]  rdata,
  output logic        done,
  output logic        busy,
  output logic [2:0]  m_address,
  output logic [31:0] m_data_o,
  input  logic [31:0] m_data_i,
  output logic        m_read,
  output logic        m_write,
  input  logic        m_stall
);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic       wr_q, wr_d;
  logic       ld_rd, ld_wr;
  logic [2:0] ld_port;
  logic [7:0] ld_data;
  logic       cmpl;
  logic [7:0] rd_byte;

  sl811_bus_cycle u_bus (
    .clk_bus   (clk_bus),
    .rst_n     (rst_n),
    .ld_rd     (ld_rd),
    .ld_wr     (ld_wr),
    .ld_port   (ld_port),
    .ld_data   (ld_data),
    .m_stall   (m_stall),
    .m_data_i  (m_data_i),
    .m_read    (m_read),
    .m_write   (m_write),
    .m_address (m_address),
    .m_data_o  (m_data_o),
    .cmpl      (cmpl),
    .rd_byte   (rd_byte)
  );

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign wdata_ready = (state_q == ST_WGET);
  assign rdata_valid = (state_q == ST_RHOLD);
  assign rdata       = rd_byte;
  assign done        = (state_q == ST_NEXT) && (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    ld_rd   = 1'b0;
    ld_wr   = 1'b0;
    ld_port = ADDR_PORT;
    ld_data = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          wr_d    = req_write;
          state_d = ST_ADDR;
          ld_wr   = 1'b1;
          ld_port = ADDR_PORT;
          ld_data = req_addr;
        end
      end
      ST_ADDR: begin
        if (cmpl) begin
          if (wr_q) begin
            state_d = ST_WGET;
          end else begin
            state_d = ST_RD;
            ld_rd   = 1'b1;
            ld_port = DATA_PORT;
          end
        end
      end
      ST_WGET: begin
        if (wdata_valid) begin
          state_d = ST_WR;
          ld_wr   = 1'b1;
          ld_port = DATA_PORT;
          ld_data = wdata;
        end
      end
      ST_WR: begin
        if (cmpl) state_d = ST_NEXT;
      end
      ST_RD: begin
        if (cmpl) state_d = ST_RHOLD;
      end
      ST_RHOLD: begin
        if (rdata_ready) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q - 8'd1;
          addr_d = addr_q + 8'd1;
          if (!AUTO_INC) begin
            state_d = ST_ADDR;
            ld_wr   = 1'b1;
            ld_port = ADDR_PORT;
            ld_data = addr_q + 8'd1;
          end else if (wr_q) begin
            state_d = ST_WGET;
          end else begin
            state_d = ST_RD;
            ld_rd   = 1'b1;
            ld_port = DATA_PORT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 8'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_sl811_access_seq.sv
// Drives two sequencers (auto-increment and per-byte address rewrite) against
// a behavioural SL811 port model and checks bus traffic and byte streams.
module tb_sl811_access_seq;

  typedef struct packed {
    logic       wr;
    logic [2:0] port;
    logic [7:0] data;
  } bus_t;

  logic clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;
  logic rst_n;

  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_write   [2];
  logic [7:0]  req_addr    [2];
  logic [7:0]  req_len     [2];
  logic        wdata_valid [2];
  logic        wdata_ready [2];
  logic [7:0]  wdata       [2];
  logic        rdata_valid [2];
  logic        rdata_ready [2];
  logic [7:0]  rdata       [2];
  logic        done        [2];
  logic        busy        [2];
  logic [2:0]  m_address   [2];
  logic [31:0] m_data_o    [2];
  logic [31:0] m_data_i    [2];
  logic        m_read      [2];
  logic        m_write     [2];
  logic        m_stall     [2] = '{1'b0, 1'b0};

  sl811_access_seq #(.ADDR_PORT(3'd0), .DATA_PORT(3'd4), .AUTO_INC(1'b1)) u_inc (
    .clk_bus(clk_bus), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_len(req_len[0]),
    .wdata_valid(wdata_valid[0]), .wdata_ready(wdata_ready[0]), .wdata(wdata[0]),
    .rdata_valid(rdata_valid[0]), .rdata_ready(rdata_ready[0]), .rdata(rdata[0]),
    .done(done[0]), .busy(busy[0]),
    .m_address(m_address[0]), .m_data_o(m_data_o[0]), .m_data_i(m_data_i[0]),
    .m_read(m_read[0]), .m_write(m_write[0]), .m_stall(m_stall[0])
  );

  sl811_access_seq #(.ADDR_PORT(3'd0), .DATA_PORT(3'd4), .AUTO_INC(1'b0)) u_noinc (
    .clk_bus(clk_bus), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_len(req_len[1]),
    .wdata_valid(wdata_valid[1]), .wdata_ready(wdata_ready[1]), .wdata(wdata[1]),
    .rdata_valid(rdata_valid[1]), .rdata_ready(rdata_ready[1]), .rdata(rdata[1]),
    .done(done[1]), .busy(busy[1]),
    .m_address(m_address[1]), .m_data_o(m_data_o[1]), .m_data_i(m_data_i[1]),
    .m_read(m_read[1]), .m_write(m_write[1]), .m_stall(m_stall[1])
  );

  // SL811 model: pointer auto-increments on data access; buffer byte at index a reads as a+0x90
  logic [7:0]  ptr       [2] = '{8'h00, 8'h00};
  bus_t        bus_log   [2][$];
  int          done_cnt  [2] = '{0, 0};
  int          viol      [2] = '{0, 0};
  logic        held      [2] = '{1'b0, 1'b0};
  logic [7:0]  held_val  [2];
  logic        pend      [2] = '{1'b0, 1'b0};
  logic [36:0] pend_val  [2];
  int          stall_len [2] = '{0, 0};
  logic        force_stall [2] = '{1'b0, 1'b0};
  int          left      [2] = '{0, 0};
  logic        prev_str  [2] = '{1'b0, 1'b0};

  assign m_data_i[0] = {24'hC3A55A, ptr[0] + 8'h90};
  assign m_data_i[1] = {24'h3CA55A, ptr[1] + 8'h90};

  always @(posedge clk_bus) begin
    for (int d = 0; d < 2; d++) begin
      int v;
      v = 0;
      if ((m_read[d] || m_write[d]) && !m_stall[d]) begin
        bus_log[d].push_back(bus_t'{m_write[d], m_address[d],
                                    m_write[d] ? m_data_o[d][7:0] : m_data_i[d][7:0]});
        if (m_write[d] && m_address[d] == 3'd0) ptr[d] <= m_data_o[d][7:0];
        else if (m_address[d] == 3'd4) ptr[d] <= ptr[d] + 8'd1;
      end
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
      if (!rst_n) begin
        held[d] <= 1'b0;
        pend[d] <= 1'b0;
      end else begin
        if (m_read[d] && m_write[d]) v++;
        if ((wdata_ready[d] || rdata_valid[d]) && (m_read[d] || m_write[d])) v++;
        if (held[d] && rdata_valid[d] && rdata[d] !== held_val[d]) v++;
        if (pend[d] && {m_read[d], m_write[d], m_address[d], m_data_o[d]} !== pend_val[d]) v++;
        held[d]     <= rdata_valid[d] && !rdata_ready[d];
        held_val[d] <= rdata[d];
        pend[d]     <= (m_read[d] || m_write[d]) && m_stall[d];
        pend_val[d] <= {m_read[d], m_write[d], m_address[d], m_data_o[d]};
      end
      viol[d] <= viol[d] + v;
    end
  end

  // A strobe seen now is a fresh access if none was up last cycle or the last one completed
  always @(negedge clk_bus) begin
    for (int d = 0; d < 2; d++) begin
      logic str;
      int   l;
      str = m_read[d] | m_write[d];
      l   = left[d];
      if (force_stall[d]) begin
        m_stall[d] <= 1'b1;
      end else if (!str) begin
        m_stall[d] <= 1'($urandom_range(0, 1));
      end else begin
        if (!prev_str[d] || !m_stall[d])
          l = (stall_len[d] >= 0) ? stall_len[d] : int'($urandom_range(0, 3));
        m_stall[d] <= (l > 0);
        if (l > 0) l--;
      end
      left[d]     <= l;
      prev_str[d] <= str;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [7:0] wq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] len,
                     input int wgap, input int rgap);
    bus_t       exp[$];
    logic [7:0] got[$];
    logic [7:0] rexp[$];
    int         base, dstart, vstart, cycles, wi, wleft, rleft;
    bit         auto_inc;
    logic [7:0] a;
    auto_inc = (d == 0);
    if (wr) while (wq.size() < int'(len) + 1) wq.push_back(8'($urandom));
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 8'(i);
      if (!auto_inc || i == 0) exp.push_back(bus_t'{1'b1, 3'd0, a});
      if (wr) exp.push_back(bus_t'{1'b1, 3'd4, wq[i]});
      else begin
        exp.push_back(bus_t'{1'b0, 3'd4, a + 8'h90});
        rexp.push_back(a + 8'h90);
      end
    end
    base   = bus_log[d].size();
    dstart = done_cnt[d];
    vstart = viol[d];
    @(negedge clk_bus);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_len[d]   = len;
    wi = 0; wleft = 0; rleft = rgap; cycles = 0;
    while (done_cnt[d] == dstart && cycles < 2000) begin
      @(negedge clk_bus);
      cycles++;
      if (cycles == 1) check("busy_after_accept", busy[d], 1);
      req_valid[d] = 1'b0;
      req_write[d] = 1'($urandom);
      req_addr[d]  = 8'($urandom);
      if (wdata_ready[d] && wleft == 0 && wi <= int'(len)) begin
        wdata_valid[d] = 1'b1;
        wdata[d]       = wq[wi];
        wi++;
        wleft = wgap;
      end else begin
        if (wdata_ready[d] && wleft > 0) wleft--;
        wdata_valid[d] = wdata_ready[d] ? 1'b0 : 1'($urandom);
        wdata[d]       = 8'($urandom);
      end
      if (rdata_valid[d]) begin
        if (rleft > 0) begin
          rdata_ready[d] = 1'b0;
          rleft--;
        end else begin
          rdata_ready[d] = 1'b1;
          got.push_back(rdata[d]);
          rleft = rgap;
        end
      end else begin
        rdata_ready[d] = 1'($urandom);
      end
    end
    check("burst_timeout", cycles < 2000, 1);
    wdata_valid[d] = 1'b0;
    rdata_ready[d] = 1'b0;
    repeat (3) @(negedge clk_bus);
    check("done_pulses", done_cnt[d] - dstart, 1);
    check("busy_idle", busy[d], 0);
    check("req_ready_idle", req_ready[d], 1);
    check("bus_cycle_count", bus_log[d].size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (base + i < bus_log[d].size()) check("bus_cycle", bus_log[d][base + i], exp[i]);
    if (!wr) begin
      check("rdata_count", got.size(), rexp.size());
      for (int i = 0; i < got.size() && i < rexp.size(); i++) check("rdata", got[i], rexp[i]);
    end
    check("protocol", viol[d] - vstart, 0);
    wq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int base, dsnap, cycles;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 8'h00; req_len[d] = 8'h00;
      wdata_valid[d] = 1'b0; wdata[d] = 8'h00; rdata_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk_bus);
    rst_n = 1'b1;
    @(negedge clk_bus);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", req_ready[d], 1);
      check("rst_outputs", {wdata_ready[d], rdata_valid[d], rdata[d], done[d], busy[d],
                            m_address[d], m_data_o[d], m_read[d], m_write[d]}, 0);
    end

    // write byte presented while idle must not be consumed
    base = bus_log[0].size();
    wdata_valid[0] = 1'b1; wdata[0] = 8'h5A;
    repeat (4) @(negedge clk_bus);
    check("idle_wdata_ready", wdata_ready[0], 0);
    check("idle_no_bus", bus_log[0].size() - base, 0);
    wdata_valid[0] = 1'b0;

    stall_len[0] = 4;
    wq.push_back(8'h08);
    run(0, 1'b1, 8'h05, 8'd0, 0, 0);

    stall_len[0] = 0;
    run(0, 1'b0, 8'h10, 8'd3, 0, 0);
    stall_len[1] = 0;
    run(1, 1'b0, 8'h10, 8'd3, 0, 0);

    stall_len[0] = 1;
    run(0, 1'b1, 8'h20, 8'd3, 5, 0);
    run(0, 1'b0, 8'h30, 8'd3, 0, 4);

    stall_len[1] = 2;
    run(1, 1'b1, 8'hFE, 8'd2, 0, 0);

    // reset while a data write is stalled
    stall_len[0] = 1;
    dsnap = done_cnt[0];
    @(negedge clk_bus);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h33; req_len[0] = 8'd0;
    @(negedge clk_bus);
    req_valid[0] = 1'b0; wdata_valid[0] = 1'b1; wdata[0] = 8'h77;
    cycles = 0;
    while (!(m_write[0] && m_address[0] == 3'd4) && cycles < 50) begin
      @(negedge clk_bus);
      cycles++;
    end
    force_stall[0] = 1'b1;
    wdata_valid[0] = 1'b0;
    check("reach_wr", cycles < 50, 1);
    @(negedge clk_bus);
    check("wr_stalled", m_write[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_write", m_write[0], 0);
    check("rst_req_ready", req_ready[0], 1);
    check("rst_busy", busy[0], 0);
    repeat (2) @(negedge clk_bus);
    force_stall[0] = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk_bus);
    check("no_done_on_reset", done_cnt[0] - dsnap, 0);
    check("idle_after_reset", {m_read[0], m_write[0], busy[0]}, 0);
    run(0, 1'b1, 8'h40, 8'd2, 1, 0);

    for (int k = 0; k < 10; k++) begin
      int d;
      d = k % 2;
      stall_len[d] = -1;
      run(d, 1'($urandom), 8'($urandom), 8'($urandom_range(0, 12)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sl811_access_seq.md
Name: sl811_access_seq

Overview:
- Bus master that turns indirect SL811 register/buffer access requests into the two-phase address-then-data cycle sequence on the usb_sl811 bus slave port.
- Phase 1 writes the register index to the address port (A0=0). Phase 2 performs 1..256 data accesses on the data port (A0=1).
- Supports burst transfers, using either SL811 address auto-increment or an explicit address rewrite per byte.
- Sits between the USB host-transfer engine (or CPU bridge) and usb_sl811; it is the sole master of that port.

Parameters:
- ADDR_PORT, 3'd0, bus_address value selecting the SL811 address register (A0=0).
- DATA_PORT, 3'd4, bus_address value selecting the SL811 data register (A0=1, bit 2).
- AUTO_INC, 1, 1: one address write per burst, relying on SL811 auto-increment; 0: rewrite the address before every data byte.

Ports:
- clk_bus  in  1  bus clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  8  starting SL811 register index
- req_len  in  8  byte count minus 1 (0 → 1 byte, 255 → 256 bytes)
- wdata_valid  in  1  write byte available
- wdata_ready  out  1  write byte consumed when valid&ready
- wdata  in  8  write byte
- rdata_valid  out  1  read byte available
- rdata_ready  in  1  consumer accepts read byte
- rdata  out  8  read byte
- done  out  1  one-cycle pulse when the burst completes
- busy  out  1  high from request accept until done
- m_address  out  3  to usb_sl811 bus_address
- m_data_o  out  32  to bus_data_i; bits [31:8] always 0
- m_data_i  in  32  from bus_data_o; only [7:0] used
- m_read  out  1  bus read strobe
- m_write  out  1  bus write strobe
- m_stall  in  1  slave busy

Behaviour:
Reset:
- Every output resets to 0, except req_ready, which resets to 1 in IDLE.
- The FSM resets to IDLE. The byte counter and address register reset to 0.

Bus handshake:
- m_read/m_write, m_address and m_data_o are registered outputs and stay stable until completion.
- A bus cycle completes on the first clk_bus edge where the strobe is high and m_stall=0.
- Read data is sampled from m_data_i[7:0] on that edge.
- The strobe drops in the following cycle.
- m_read and m_write are never both high.

FSM states:
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, len, write; cnt←len; go to ADDR.
- ADDR:
  - m_write=1, m_address=ADDR_PORT, m_data_o={24'h0,addr}.
  - On completion, go to WGET if writing, else RD.
- WGET:
  - wdata_ready=1.
  - On wdata_valid, latch the byte and go to WR.
  - Waits indefinitely; no bus strobe is active in this state.
- WR:
  - m_write=1, m_address=DATA_PORT, m_data_o={24'h0,byte}.
  - On completion, go to NEXT.
- RD:
  - m_read=1, m_address=DATA_PORT.
  - On completion, capture rdata and go to RHOLD.
- RHOLD:
  - rdata_valid=1.
  - On rdata_ready, go to NEXT.
  - rdata stays stable while held.
- NEXT (single cycle):
  - If cnt==0: pulse done and return to IDLE.
  - Otherwise: cnt←cnt-1 and addr←addr+1 (8-bit wrap, 0xFF→0x00).
  - Then go to ADDR if AUTO_INC=0; if AUTO_INC=1, go to WGET (write) or RD (read).

Other rules:
- busy=1 in every state except IDLE.
- A new request is accepted no earlier than the cycle after the done pulse.
- Inputs are ignored outside the states that consume them. wdata_valid in IDLE is not consumed.
- Reset asserted mid-burst: strobes drop asynchronously and the FSM returns to IDLE. No partial done pulse is issued.
- Throughput, write burst with AUTO_INC=1 and zero stall: 1 WGET cycle + 1 WR cycle + 1 NEXT cycle = 3 cycles/byte, plus the usb_sl811 stall time.

Decomposition:
Shared package sl811_pkg:
- State enum.
- ADDR_PORT/DATA_PORT defaults.
- SL811 register index constants (CTRL1=8'h05, INT_STATUS=8'h0D, etc.) for the engine above.

No sub-module required; one optional helper, sl811_bus_cycle, for the strobe/stall completion logic, shared by ADDR/WR/RD.

Test Plan:
- Single-byte write, req_addr=8'h05, data 8'h08, m_stall held 4 cycles per access → exactly two bus writes: (addr 0, data 0x05), then (addr 4, data 0x08); done pulses once; busy low afterwards.
- Read burst, req_addr=8'h10, req_len=3, AUTO_INC=1, model returns 0xA0..0xA3 → one address write, four reads on port 4; rdata sequence A0,A1,A2,A3; done after the 4th rdata handshake.
- Same read with AUTO_INC=0 → the address writes 0x10,0x11,0x12,0x13 each precede their data read; 8 bus cycles in total.
- Write burst with wdata_valid gapped by 5 cycles and rdata_ready stalled in the read case → no bus strobe during the gaps; rdata stays stable until ready; no byte lost or duplicated.
- Address wrap: req_addr=8'hFE, req_len=2, AUTO_INC=0 → address writes FE, FF, 00.
- Reset asserted during a WR cycle with m_stall=1 → m_write=0 immediately, req_ready=1 after release, no done pulse; a fresh request then completes normally.
